// File: rtl/mux_l2_tx.sv
// mux_l2_tx: two-lane FIFO-buffered byte interleaver with fixed lane 0 / lane 1 slot order
module mux_l2_tx #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] IDLE_BYTE = '0
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_0,
  input  logic              valid_0,
  output logic              ready_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic              valid_1,
  output logic              ready_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic sel;
  logic [1:0] valid, ready, push, pop;
  logic [1:0][DATA_W-1:0] din, head;
  assign valid = {valid_1, valid_0};
  assign din = {data_1, data_0};
  assign ready_0 = ready[0];
  assign ready_1 = ready[1];
  for (genvar g = 0; g < 2; g++) begin : lane
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    assign ready[g] = cnt != FULL;
    assign push[g] = valid[g] && ready[g];
    assign pop[g] = sel == 1'(g) && cnt != '0;
    assign head[g] = mem[rp];
    always_ff @(posedge clk_4f)
      if (push[g]) mem[wp] <= din[g];
    always_ff @(posedge clk_4f or posedge reset)
      if (reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        wp <= wp + AW'(push[g]);
        rp <= rp + AW'(pop[g]);
        cnt <= cnt + (AW+1)'(push[g]) - (AW+1)'(pop[g]);
      end
  end
  // Empty slots still toggle sel so the far end can split bytes by position.
  always_ff @(posedge clk_4f or posedge reset)
    if (reset) begin
      sel <= 1'b0;
      data_out <= IDLE_BYTE;
      valid_out <= 1'b0;
      lane_out <= 1'b0;
    end else begin
      lane_out <= sel;
      valid_out <= pop[sel];
      data_out <= pop[sel] ? head[sel] : IDLE_BYTE;
      sel <= ~sel;
    end
endmodule

// File: tb/tb_mux_l2_tx.sv
// tb_mux_l2_tx: randomized scoreboard bench for the two-lane byte interleaver
module tb_mux_l2_tx;
  localparam int DEPTH = 4;
  logic clk_4f = 1'b0;
  logic reset = 1'b1;
  logic [7:0] data_0 = '0, data_1 = '0;
  logic valid_0 = 1'b0, valid_1 = 1'b0;
  logic ready_0, ready_1, valid_out, lane_out;
  logic [7:0] data_out;

  mux_l2_tx dut (
    .clk_4f(clk_4f), .reset(reset),
    .data_0(data_0), .valid_0(valid_0), .ready_0(ready_0),
    .data_1(data_1), .valid_1(valid_1), .ready_1(ready_1),
    .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out)
  );

  always #5 clk_4f = ~clk_4f;

  typedef struct {logic v; logic l; logic [7:0] d;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] mq0[$], mq1[$], src0[$], src1[$];
  logic msel = 1'b0;
  bit active = 1'b0;
  int pass_n = 0, total_n = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total_n++;
    if (act === req) pass_n++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: one expected slot per clock edge while active.
  always @(posedge clk_4f) begin
    #1;
    if (active) begin
      if (exp_q.size() == 0) begin
        total_n++;
        $display("FAIL scoreboard_empty: got slot valid=%0b with no expectation", valid_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("lane_out", lane_out, mon_e.l);
        chk("valid_out", valid_out, mon_e.v);
        chk("data_out", data_out, mon_e.d);
      end
    end
  end

  // Called at a negedge: drive sources, predict the next edge's slot, wait one cycle.
  task automatic step();
    exp_t e;
    bit r0, r1;
    valid_0 = src0.size() > 0;
    valid_1 = src1.size() > 0;
    data_0 = valid_0 ? src0[0] : 8'($urandom);
    data_1 = valid_1 ? src1[0] : 8'($urandom);
    r0 = mq0.size() != DEPTH;
    r1 = mq1.size() != DEPTH;
    #1;
    chk("ready_0", ready_0, r0);
    chk("ready_1", ready_1, r1);
    e.l = msel;
    e.v = 1'b0;
    e.d = 8'h00;
    if (msel == 1'b0 && mq0.size() > 0) begin e.v = 1'b1; e.d = mq0.pop_front(); end
    if (msel == 1'b1 && mq1.size() > 0) begin e.v = 1'b1; e.d = mq1.pop_front(); end
    if (valid_0 && r0) mq0.push_back(src0.pop_front());
    if (valid_1 && r1) mq1.push_back(src1.pop_front());
    msel = ~msel;
    exp_q.push_back(e);
    @(negedge clk_4f);
  endtask

  task automatic pulse_reset();
    active = 1'b0;
    #2 reset = 1'b1;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    #1;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_lane_out", lane_out, 1'b0);
    chk("rst_ready_0", ready_0, 1'b1);
    chk("rst_ready_1", ready_1, 1'b1);
    exp_q.delete(); mq0.delete(); mq1.delete(); src0.delete(); src1.delete();
    msel = 1'b0;
    @(negedge clk_4f);
    reset = 1'b0;
    active = 1'b1;
  endtask

  initial begin
    pulse_reset();
    repeat (4) step();
    src0 = '{8'hFF, 8'hBB, 8'hEA};
    src1 = '{8'hEE, 8'hAA, 8'hDE};
    repeat (10) step();
    src1 = '{8'h15, 8'h16};
    repeat (8) step();
    for (int i = 1; i <= 8; i++) src0.push_back(8'(i));
    repeat (24) step();
    for (int i = 0; i < 6; i++) src0.push_back(8'hC0 + 8'(i));
    repeat (5) step();
    pulse_reset();
    repeat (8) step();
    for (int n = 0; n < 400; n++) begin
      if (src0.size() < 3 && $urandom_range(2) != 0) src0.push_back(8'($urandom));
      if (src1.size() < 3 && $urandom_range(2) != 0) src1.push_back(8'($urandom));
      step();
    end
    repeat (12) step();
    active = 1'b0;
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
